// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester, memory and status signals around the unified memory port arbiter.
// slave: the arbiter itself; master: the requesters plus the memory it talks to.
interface mem_port_arbiter_if #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32
);
   logic                  if_req;
   logic [ADDR_W-1:0]     if_addr;
   logic                  if_gnt;
   logic                  if_rvalid;
   logic [DATA_W-1:0]     if_rdata;

   logic                  d_req;
   logic                  d_we;
   logic [DATA_W/8-1:0]   d_be;
   logic [ADDR_W-1:0]     d_addr;
   logic [DATA_W-1:0]     d_wdata;
   logic                  d_gnt;
   logic                  d_rvalid;
   logic [DATA_W-1:0]     d_rdata;

   logic                  mem_req;
   logic                  mem_we;
   logic [DATA_W/8-1:0]   mem_be;
   logic [ADDR_W-1:0]     mem_addr;
   logic [DATA_W-1:0]     mem_wdata;
   logic                  mem_ack;
   logic [DATA_W-1:0]     mem_rdata;

   logic                  busy;
   logic                  err;

   modport slave (
      input  if_req, if_addr, d_req, d_we, d_be, d_addr, d_wdata, mem_ack, mem_rdata,
      output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
      output mem_req, mem_we, mem_be, mem_addr, mem_wdata, busy, err
   );

   modport master (
      output if_req, if_addr, d_req, d_we, d_be, d_addr, d_wdata, mem_ack, mem_rdata,
      input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
      input  mem_req, mem_we, mem_be, mem_addr, mem_wdata, busy, err
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and data load/store, one transaction at a time.
// Define MEM_ARB_TIMEOUT_EN to abort a WAIT that sees no mem_ack within TIMEOUT_CYCLES (sets err).
module mem_port_arbiter #(
   parameter int unsigned ADDR_W         = 32,
   parameter int unsigned DATA_W         = 32,
   parameter int unsigned STARVE_MAX     = 4,
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input logic              clk,
   input logic              reset,
   mem_port_arbiter_if.slave bus
);
   localparam int unsigned BE_W = DATA_W / 8;
   localparam int unsigned SW   = $clog2(STARVE_MAX + 1);

   typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

   state_e              state_q;
   logic                owner_q;  // 1: data owns the port, 0: fetch
   logic [SW-1:0]       starve_q;
   logic                if_gnt_q, if_rvalid_q, d_gnt_q, d_rvalid_q;
   logic [DATA_W-1:0]   if_rdata_q, d_rdata_q;
   logic                mem_req_q, mem_we_q, busy_q;
   logic [BE_W-1:0]     mem_be_q;
   logic [ADDR_W-1:0]   mem_addr_q;
   logic [DATA_W-1:0]   mem_wdata_q;
`ifdef MEM_ARB_TIMEOUT_EN
   localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
   logic [TW-1:0]       tmo_q;
   logic                err_q;
`endif

   logic starved, pick_data;
   assign starved   = (starve_q == SW'(STARVE_MAX));
   assign pick_data = bus.d_req && !(bus.if_req && starved);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= StIdle;
         owner_q     <= 1'b0;
         starve_q    <= '0;
         if_gnt_q    <= 1'b0;
         if_rvalid_q <= 1'b0;
         if_rdata_q  <= '0;
         d_gnt_q     <= 1'b0;
         d_rvalid_q  <= 1'b0;
         d_rdata_q   <= '0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_be_q    <= '0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         busy_q      <= 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
         tmo_q       <= '0;
         err_q       <= 1'b0;
`endif
      end else begin
         if_gnt_q    <= 1'b0;
         d_gnt_q     <= 1'b0;
         if_rvalid_q <= 1'b0;
         d_rvalid_q  <= 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
         err_q       <= 1'b0;
`endif
         if (!bus.if_req) starve_q <= '0;

         unique case (state_q)
            StIdle: begin
               if (bus.if_req || bus.d_req) begin
                  state_q   <= StWait;
                  busy_q    <= 1'b1;
                  mem_req_q <= 1'b1;
                  owner_q   <= pick_data;
`ifdef MEM_ARB_TIMEOUT_EN
                  tmo_q     <= '0;
`endif
                  if (pick_data) begin
                     d_gnt_q     <= 1'b1;
                     mem_we_q    <= bus.d_we;
                     mem_be_q    <= bus.d_be;
                     mem_addr_q  <= bus.d_addr;
                     mem_wdata_q <= bus.d_wdata;
                     // Data cannot win at STARVE_MAX with fetch pending, so this saturates.
                     if (bus.if_req) starve_q <= starve_q + SW'(1);
                  end else begin
                     if_gnt_q    <= 1'b1;
                     mem_we_q    <= 1'b0;
                     mem_be_q    <= '1;
                     mem_addr_q  <= bus.if_addr;
                     mem_wdata_q <= '0;
                     starve_q    <= '0;
                  end
               end
            end
            StWait: begin
               if (bus.mem_ack) begin
                  state_q   <= StResp;
                  mem_req_q <= 1'b0;
                  if (owner_q) begin
                     d_rvalid_q <= 1'b1;
                     d_rdata_q  <= mem_we_q ? '0 : bus.mem_rdata;
                  end else begin
                     if_rvalid_q <= 1'b1;
                     if_rdata_q  <= bus.mem_rdata;
                  end
               end
`ifdef MEM_ARB_TIMEOUT_EN
               else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
                  state_q   <= StResp;
                  mem_req_q <= 1'b0;
                  err_q     <= 1'b1;
                  if (owner_q) begin
                     d_rvalid_q <= 1'b1;
                     d_rdata_q  <= '0;
                  end else begin
                     if_rvalid_q <= 1'b1;
                     if_rdata_q  <= '0;
                  end
               end else begin
                  tmo_q <= tmo_q + TW'(1);
               end
`endif
            end
            StResp: begin
               state_q <= StIdle;
               busy_q  <= 1'b0;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign bus.if_gnt    = if_gnt_q;
   assign bus.if_rvalid = if_rvalid_q;
   assign bus.if_rdata  = if_rdata_q;
   assign bus.d_gnt     = d_gnt_q;
   assign bus.d_rvalid  = d_rvalid_q;
   assign bus.d_rdata   = d_rdata_q;
   assign bus.mem_req   = mem_req_q;
   assign bus.mem_we    = mem_we_q;
   assign bus.mem_be    = mem_be_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wdata = mem_wdata_q;
   assign bus.busy      = busy_q;
`ifdef MEM_ARB_TIMEOUT_EN
   assign bus.err       = err_q;
`else
   assign bus.err       = 1'b0;
`endif
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: vector table of single transactions, scoreboard of responses,
// plus contention, reset-in-WAIT, stray-ack and timeout sequences.
module tb_mem_port_arbiter;
   localparam int unsigned AW = 32;
   localparam int unsigned DW = 32;
   localparam int unsigned BW = DW / 8;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

   mem_port_arbiter #(
      .ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(4), .TIMEOUT_CYCLES(16)
   ) dut (
      .clk(clk), .reset(reset), .bus(bus)
   );

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   // Memory model: acks after ws extra wait cycles; ack_force drives a stray ack.
   int ws        = 0;
   bit ack_en    = 1'b1;
   bit ack_force = 1'b0;
   int mcnt      = 0;

   function automatic logic [DW-1:0] mem_fn(input logic [AW-1:0] a);
      if (a == 32'h100) return 32'h0050_0093;
      return {a[15:0], ~a[15:0]};
   endfunction

   always @(negedge clk) begin
      if (ack_force) begin
         bus.mem_ack   = 1'b1;
         bus.mem_rdata = 32'hDEAD_BEEF;
      end else if (bus.mem_req && ack_en && bus.mem_ack !== 1'b1) begin
         if (mcnt >= ws) begin
            bus.mem_ack   = 1'b1;
            bus.mem_rdata = mem_fn(bus.mem_addr);
            mcnt          = 0;
         end else begin
            bus.mem_ack = 1'b0;
            mcnt++;
         end
      end else begin
         bus.mem_ack   = 1'b0;
         bus.mem_rdata = '0;
         mcnt          = 0;
      end
   end

   // Scoreboard of expected responses, in order.
   typedef struct {
      logic          owner;
      logic [DW-1:0] rdata;
      logic          err;
   } exp_t;
   exp_t sb[$];
   exp_t e;

   function automatic void push_exp(input logic owner, input logic [DW-1:0] rdata,
                                    input logic err);
      exp_t x;
      x.owner = owner;
      x.rdata = rdata;
      x.err   = err;
      sb.push_back(x);
   endfunction

   always @(negedge clk) begin
      if (reset === 1'b0 && (bus.if_rvalid || bus.d_rvalid || bus.err)) begin
         check("rvalid_single", 64'(bus.if_rvalid & bus.d_rvalid), 64'd0);
         check("err_with_rvalid", 64'(bus.if_rvalid | bus.d_rvalid), 64'd1);
         check("rvalid_expected", 64'(sb.size() != 0), 64'd1);
         if (sb.size() != 0) begin
            e = sb.pop_front();
            check("rvalid_owner", 64'(bus.d_rvalid), 64'(e.owner));
            check("rdata", 64'(bus.d_rvalid ? bus.d_rdata : bus.if_rdata), 64'(e.rdata));
            check("err", 64'(bus.err), 64'(e.err));
         end
      end
   end

   typedef struct {
      bit            is_data;
      bit            we;
      logic [BW-1:0] be;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
      int            ws;
      logic [DW-1:0] exp_rdata;
   } vec_t;
   vec_t vecs[6];

   int lat, nreq, t;
   bit stable, seen;

   initial begin
      vecs[0] = '{1'b0, 1'b0, 4'h0, 32'h0000_0100, 32'h0,          0, 32'h0050_0093};
      vecs[1] = '{1'b1, 1'b1, 4'hF, 32'h0000_0200, 32'hCAFE_F00D,  2, 32'h0};
      vecs[2] = '{1'b1, 1'b0, 4'h0, 32'h0000_0344, 32'h0,          1, 32'h0344_FCBB};
      vecs[3] = '{1'b0, 1'b0, 4'h0, 32'h0000_0104, 32'h0,          3, 32'h0104_FEFB};
      vecs[4] = '{1'b1, 1'b1, 4'h3, 32'h0000_0080, 32'h1234_5678,  0, 32'h0};
      vecs[5] = '{1'b1, 1'b0, 4'h0, 32'hFFFF_FFFC, 32'h0,          0, 32'hFFFC_0003};

      reset = 1'b1;
      bus.if_req = 1'b0; bus.if_addr = '0;
      bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_be = '0; bus.d_addr = '0; bus.d_wdata = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_gnt", {bus.if_gnt, bus.d_gnt}, 0);
      check("rst_rvalid", {bus.if_rvalid, bus.d_rvalid}, 0);
      check("rst_rdata", {bus.if_rdata, bus.d_rdata}, 0);
      check("rst_mem_req_we_busy_err", {bus.mem_req, bus.mem_we, bus.busy, bus.err}, 0);
      check("rst_mem_fields", {bus.mem_be, bus.mem_addr, bus.mem_wdata}, 0);
      reset = 1'b0;

      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         ws = vecs[i].ws;
         if (vecs[i].is_data) begin
            bus.d_req = 1'b1; bus.d_we = vecs[i].we; bus.d_be = vecs[i].be;
            bus.d_addr = vecs[i].addr; bus.d_wdata = vecs[i].wdata;
         end else begin
            bus.if_req = 1'b1; bus.if_addr = vecs[i].addr;
         end
         push_exp(vecs[i].is_data, vecs[i].exp_rdata, 1'b0);
         @(posedge clk);
         #1;
         check("gnt_owner", {bus.if_gnt, bus.d_gnt}, vecs[i].is_data ? 2'b01 : 2'b10);
         check("mem_req", bus.mem_req, 1);
         check("mem_addr", bus.mem_addr, vecs[i].addr);
         check("mem_we", bus.mem_we, vecs[i].is_data & vecs[i].we);
         if (vecs[i].is_data) begin
            check("mem_be", bus.mem_be, vecs[i].be);
            check("mem_wdata", bus.mem_wdata, vecs[i].wdata);
         end
         bus.if_req = 1'b0;
         bus.d_req  = 1'b0;
         lat = 1; nreq = 1; stable = 1'b1;
         while (bus.busy && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
            if (bus.mem_req) begin
               nreq++;
               if (bus.mem_addr !== vecs[i].addr || bus.mem_we !== (vecs[i].is_data & vecs[i].we))
                  stable = 1'b0;
               if (vecs[i].is_data && bus.mem_wdata !== vecs[i].wdata) stable = 1'b0;
            end
         end
         check("latency_to_idle", lat, 3 + vecs[i].ws);
         check("mem_req_cycles", nreq, vecs[i].ws + 1);
         check("mem_fields_held", stable, 1);
      end
      check("sb_drained_vectors", sb.size(), 0);

      // Contention: both held, data wins 4 times then fetch is forced.
      @(negedge clk);
      ws = 0;
      bus.if_addr = 32'h300; bus.d_addr = 32'h400; bus.d_we = 1'b0;
      bus.if_req = 1'b1; bus.d_req = 1'b1;
      for (int g = 0; g < 10; g++) begin
         if (g % 5 == 4) push_exp(1'b0, 32'h0300_FCFF, 1'b0);
         else push_exp(1'b1, 32'h0400_FBFF, 1'b0);
      end
      for (int g = 0; g < 10; g++) begin
         t = 0;
         do begin
            @(posedge clk);
            #1;
            t++;
         end while (!(bus.if_gnt || bus.d_gnt) && t < 20);
         check("contention_grant", {bus.if_gnt, bus.d_gnt}, (g % 5 == 4) ? 2'b10 : 2'b01);
      end
      bus.if_req = 1'b0; bus.d_req = 1'b0;
      t = 0;
      while (bus.busy && t < 20) begin
         @(posedge clk);
         #1;
         t++;
      end
      check("contention_idle", bus.busy, 0);
      check("sb_drained_contention", sb.size(), 0);

      // Reset during the second WAIT cycle drops the transaction and clears starvation.
      @(negedge clk);
      ack_en = 1'b0;
      bus.if_req = 1'b1; bus.if_addr = 32'h500;
      bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h40;
      @(posedge clk);
      #1;
      check("rstwait_gnt", {bus.if_gnt, bus.d_gnt}, 2'b01);
      bus.d_req = 1'b0;
      @(posedge clk);
      #1;
      check("rstwait_starve_before", dut.starve_q, 1);
      check("rstwait_mem_req_before", bus.mem_req, 1);
      reset = 1'b1;
      @(posedge clk);
      #1;
      check("rstwait_mem_req", bus.mem_req, 0);
      check("rstwait_busy", bus.busy, 0);
      check("rstwait_starve", dut.starve_q, 0);
      bus.if_req = 1'b0;
      reset = 1'b0;
      ack_en = 1'b1;
      seen = 1'b0;
      repeat (5) begin
         @(posedge clk);
         #1;
         if (bus.if_rvalid || bus.d_rvalid || bus.busy) seen = 1'b1;
      end
      check("rstwait_quiet", seen, 0);

      // A stray ack while idle must not start or complete anything.
      @(posedge clk);
      #1 ack_force = 1'b1;
      @(posedge clk);
      #1 ack_force = 1'b0;
      check("stray_ack_busy", bus.busy, 0);
      check("stray_ack_rvalid", {bus.if_rvalid, bus.d_rvalid}, 0);

      // Load with no ack ever.
      @(negedge clk);
      ack_en = 1'b0;
      bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h60;
`ifdef MEM_ARB_TIMEOUT_EN
      push_exp(1'b1, 32'h0, 1'b1);
`endif
      @(posedge clk);
      #1;
      check("tmo_gnt", {bus.if_gnt, bus.d_gnt}, 2'b01);
      bus.d_req = 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
      lat = 1; nreq = 1;
      while (bus.busy && lat < 60) begin
         @(posedge clk);
         #1;
         lat++;
         if (bus.mem_req) nreq++;
      end
      check("tmo_mem_req_cycles", nreq, 16);
      check("tmo_latency_to_idle", lat, 18);
`else
      repeat (100) @(posedge clk);
      #1;
      check("noto_busy", bus.busy, 1);
      check("noto_mem_req", bus.mem_req, 1);
      check("noto_err", bus.err, 0);
      reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
`endif
      ack_en = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("sb_drained_final", sb.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, checks %0d passed %0d", n_checks, n_pass);
      $fatal(1, "watchdog");
   end
endmodule
